alu_req_arbiter: RTL and testbench

- Shares one alu_8bit instance between two independent requesters using round-robin or fixed-priority arbitration.
- Latches the winning request's operands and select, and holds them on the ALU inputs for LAT_CYCLES cycles.
- Captures Y/zero/carry and returns them on a single tagged response channel with a valid/ready handshake.
- Sits between the top-level tt_um_* wrapper and alu_8bit; the ALU itself stays combinational and unmodified.

---
 rtl/alu_req_arbiter_if.sv | 33 +++
 rtl/alu_req_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the requester, ALU and response channels around alu_req_arbiter.
//   slave  : arbiter side (takes requests and ALU results, drives readies,
//            ALU operands and the tagged response)
//   master : environment side (requesters, ALU, response consumer)
interface alu_req_arbiter_if;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req1_a;
  logic [3:0] req0_b, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_y;
  logic       alu_zero, alu_carry;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_y;
  logic       rsp_zero, rsp_carry;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
           req0_sel, req1_sel, alu_y, alu_zero, alu_carry, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
           rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
           req0_sel, req1_sel, alu_y, alu_zero, alu_carry, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
           rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Shares one combinational alu_8bit between two requesters.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   ena        : gates acceptance of new requests only
//   bus        : request channels, ALU operand/result lines, tagged
//                valid/ready response channel
//   busy       : high while an op is executing or awaiting response handshake
//   ops_done   : completed response handshakes, wraps at 256
module alu_req_arbiter #(
  parameter int unsigned LAT_CYCLES = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  alu_req_arbiter_if.slave bus,
  output logic             busy,
  output logic [7:0]       ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_y_q, rsp_y_d;
  logic       rsp_zero_q, rsp_zero_d, rsp_carry_q, rsp_carry_d;
  logic [7:0] ops_q, ops_d;
  logic       win0, win1, rdy0, rdy1;

  // r0 wins a tie under fixed priority, or when r1 had the last grant
  assign win0 = bus.req0_valid &
                (~bus.req1_valid | (FIXED_PRIO != 0) | last_q);
  assign win1 = bus.req1_valid & ~win0;
  assign rdy0 = (state_q == IDLE) & ena & win0;
  assign rdy1 = (state_q == IDLE) & ena & win1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_carry_d = rsp_carry_q;
    ops_d       = ops_q;
    case (state_q)
      IDLE: begin
        if (rdy0 | rdy1) begin
          alu_a_d   = rdy1 ? bus.req1_a   : bus.req0_a;
          alu_b_d   = rdy1 ? bus.req1_b   : bus.req0_b;
          alu_sel_d = rdy1 ? bus.req1_sel : bus.req0_sel;
          rsp_id_d  = rdy1;
          last_d    = rdy1;
          cnt_d     = CNT_INIT;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_y_d     = bus.alu_y;
          rsp_zero_d  = bus.alu_zero;
          rsp_carry_d = bus.alu_carry;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ops_d   = ops_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_carry_q <= rsp_carry_d;
      ops_q       <= ops_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign busy           = (state_q != IDLE);
  assign ops_done       = ops_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter. Three instances: LAT=1 round-robin (a),
// LAT=1 fixed priority (b), LAT=4 round-robin (c). Each ALU is a stub:
// y = a+b zero-extended, zero = (y==0), carry = y[4].
module tb_alu_req_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic busy_a, busy_b, busy_c;
  logic [7:0] ops_a, ops_b, ops_c;
  int nvec = 0;
  int nerr = 0;

  alu_req_arbiter_if ifa ();
  alu_req_arbiter_if ifb ();
  alu_req_arbiter_if ifc ();

  always #5 clk = ~clk;

  assign ifa.alu_y     = {4'b0, ifa.alu_a} + {4'b0, ifa.alu_b};
  assign ifa.alu_zero  = (ifa.alu_y == 8'd0);
  assign ifa.alu_carry = ifa.alu_y[4];
  assign ifb.alu_y     = {4'b0, ifb.alu_a} + {4'b0, ifb.alu_b};
  assign ifb.alu_zero  = (ifb.alu_y == 8'd0);
  assign ifb.alu_carry = ifb.alu_y[4];
  assign ifc.alu_y     = {4'b0, ifc.alu_a} + {4'b0, ifc.alu_b};
  assign ifc.alu_zero  = (ifc.alu_y == 8'd0);
  assign ifc.alu_carry = ifc.alu_y[4];

  alu_req_arbiter #(.LAT_CYCLES(1), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifa), .busy(busy_a), .ops_done(ops_a));
  alu_req_arbiter #(.LAT_CYCLES(1), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifb), .busy(busy_b), .ops_done(ops_b));
  alu_req_arbiter #(.LAT_CYCLES(4), .FIXED_PRIO(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(ifc), .busy(busy_c), .ops_done(ops_c));

  // Leaves the bench at a falling edge, reset released, all DUTs in IDLE.
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    ifa.req0_valid = 0; ifa.req1_valid = 0; ifa.rsp_ready = 1;
    ifb.req0_valid = 0; ifb.req1_valid = 0; ifb.rsp_ready = 1;
    ifc.req0_valid = 0; ifc.req1_valid = 0; ifc.rsp_ready = 1;
    ifa.req0_a = 0; ifa.req0_b = 0; ifa.req0_sel = 0;
    ifa.req1_a = 0; ifa.req1_b = 0; ifa.req1_sel = 0;
    ifb.req0_a = 0; ifb.req0_b = 0; ifb.req0_sel = 0;
    ifb.req1_a = 0; ifb.req1_b = 0; ifb.req1_sel = 0;
    ifc.req0_a = 0; ifc.req0_b = 0; ifc.req0_sel = 0;
    ifc.req1_a = 0; ifc.req1_b = 0; ifc.req1_sel = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    nvec++;
    if ({busy_a, ifa.rsp_valid, ifa.alu_a, ifa.alu_b, ifa.alu_sel} !== 14'd0) begin
      $display("FAIL reset_ctrl: got %0h expected 0",
               {busy_a, ifa.rsp_valid, ifa.alu_a, ifa.alu_b, ifa.alu_sel}); nerr++;
    end
    nvec++;
    if ({ifa.rsp_id, ifa.rsp_y, ifa.rsp_zero, ifa.rsp_carry, ops_a} !== 19'd0) begin
      $display("FAIL reset_rsp: got %0h expected 0",
               {ifa.rsp_id, ifa.rsp_y, ifa.rsp_zero, ifa.rsp_carry, ops_a}); nerr++;
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    do_reset();
    // k0: ena low blocks acceptance
    ena = 0; ifa.req0_valid = 1; ifa.req0_a = 4'h3; ifa.req0_b = 4'h4; ifa.req0_sel = 3'd0;
    #1; nvec++;
    if (ifa.req0_ready !== 1'b0) begin
      $display("FAIL ena_block: got %b expected 0", ifa.req0_ready); nerr++;
    end
    @(negedge clk);
    // k1: accepted
    ena = 1; #1; nvec++;
    if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin
      $display("FAIL single_ready: got %b expected 10", {ifa.req0_ready, ifa.req1_ready}); nerr++;
    end
    @(negedge clk);
    // k2: EXEC
    ifa.req0_valid = 0; #1; nvec++;
    if ({busy_a, ifa.rsp_valid, ifa.alu_a, ifa.alu_b, ifa.alu_sel} !== {2'b10, 4'h3, 4'h4, 3'd0}) begin
      $display("FAIL single_exec: got %0h expected %0h",
               {busy_a, ifa.rsp_valid, ifa.alu_a, ifa.alu_b, ifa.alu_sel}, {2'b10, 4'h3, 4'h4, 3'd0}); nerr++;
    end
    @(negedge clk);
    // k3: response (t+2)
    #1; nvec++;
    if ({ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y, ifa.rsp_zero, ifa.rsp_carry, ops_a} !== {2'b10, 8'h07, 2'b00, 8'd0}) begin
      $display("FAIL single_rsp: got %0h expected %0h",
               {ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y, ifa.rsp_zero, ifa.rsp_carry, ops_a},
               {2'b10, 8'h07, 2'b00, 8'd0}); nerr++;
    end
    @(negedge clk);
    // k4: back in IDLE, results and operands held
    #1; nvec++;
    if ({busy_a, ifa.rsp_valid, ops_a, ifa.rsp_y, ifa.alu_a} !== {2'b00, 8'd1, 8'h07, 4'h3}) begin
      $display("FAIL single_after: got %0h expected %0h",
               {busy_a, ifa.rsp_valid, ops_a, ifa.rsp_y, ifa.alu_a}, {2'b00, 8'd1, 8'h07, 4'h3}); nerr++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    logic       exp_id;
    do_reset();
    ifa.req0_valid = 1; ifa.req0_a = 4'h1; ifa.req0_b = 4'h2;
    ifa.req1_valid = 1; ifa.req1_a = 4'h5; ifa.req1_b = 4'h6;
    for (int k = 0; k < 12; k++) begin
      exp_id  = ((k / 3) % 2) == 1;
      exp_rdy = (k % 3 == 0) ? (exp_id ? 2'b01 : 2'b10) : 2'b00;
      #1; nvec++;
      if ({ifa.req0_ready, ifa.req1_ready} !== exp_rdy) begin
        $display("FAIL rr_ready k=%0d: got %b expected %b", k, {ifa.req0_ready, ifa.req1_ready}, exp_rdy); nerr++;
      end
      if (k % 3 == 2) begin
        nvec++;
        if ({ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y} !== {1'b1, exp_id, exp_id ? 8'd11 : 8'd3}) begin
          $display("FAIL rr_rsp k=%0d: got %0h expected %0h", k, {ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y},
                   {1'b1, exp_id, exp_id ? 8'd11 : 8'd3}); nerr++;
        end
      end
      @(negedge clk);
    end
    ifa.req0_valid = 0; ifa.req1_valid = 0;
  endtask

  task automatic test_fixed_prio();
    do_reset();
    ifb.req0_valid = 1; ifb.req0_a = 4'h2; ifb.req0_b = 4'h2;
    ifb.req1_valid = 1; ifb.req1_a = 4'h9; ifb.req1_b = 4'h9;
    for (int k = 0; k < 12; k++) begin
      #1; nvec++;
      if ({ifb.req0_ready, ifb.req1_ready} !== ((k % 3 == 0) ? 2'b10 : 2'b00)) begin
        $display("FAIL fixed_ready k=%0d: got %b expected %b", k, {ifb.req0_ready, ifb.req1_ready},
                 (k % 3 == 0) ? 2'b10 : 2'b00); nerr++;
      end
      @(negedge clk);
    end
    #1; nvec++;
    if (ops_b !== 8'd4) begin
      $display("FAIL fixed_ops: got %0d expected 4", ops_b); nerr++;
    end
    ifb.req0_valid = 0; ifb.req1_valid = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ifa.rsp_ready = 0;
    ifa.req1_valid = 1; ifa.req1_a = 4'hF; ifa.req1_b = 4'h1;
    #1; nvec++;
    if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) begin
      $display("FAIL bp_accept: got %b expected 01", {ifa.req0_ready, ifa.req1_ready}); nerr++;
    end
    @(negedge clk);
    ifa.req1_valid = 0; ifa.req0_valid = 1; ifa.req0_a = 4'h1; ifa.req0_b = 4'h1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1; nvec++;
      if ({ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y, ifa.rsp_zero, ifa.rsp_carry, ifa.req0_ready, ops_a} !==
          {2'b11, 8'h10, 2'b01, 1'b0, 8'd0}) begin
        $display("FAIL bp_hold k=%0d: got %0h expected %0h", k,
                 {ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y, ifa.rsp_zero, ifa.rsp_carry, ifa.req0_ready, ops_a},
                 {2'b11, 8'h10, 2'b01, 1'b0, 8'd0}); nerr++;
      end
      @(negedge clk);
    end
    ifa.rsp_ready = 1; ifa.req0_valid = 0;
    @(negedge clk);
    #1; nvec++;
    if ({ifa.rsp_valid, ops_a, ifa.rsp_y, ifa.rsp_id} !== {1'b0, 8'd1, 8'h10, 1'b1}) begin
      $display("FAIL bp_release: got %0h expected %0h", {ifa.rsp_valid, ops_a, ifa.rsp_y, ifa.rsp_id},
               {1'b0, 8'd1, 8'h10, 1'b1}); nerr++;
    end
  endtask

  task automatic test_latency4();
    do_reset();
    ifc.req0_valid = 1; ifc.req0_a = 4'h0; ifc.req0_b = 4'h0; ifc.req0_sel = 3'd5;
    #1; nvec++;
    if (ifc.req0_ready !== 1'b1) begin
      $display("FAIL lat4_accept: got %b expected 1", ifc.req0_ready); nerr++;
    end
    @(negedge clk);
    ifc.req0_valid = 0; ifc.req0_sel = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      #1; nvec++;
      if ({busy_c, ifc.rsp_valid, ifc.alu_a, ifc.alu_b, ifc.alu_sel} !== {2'b10, 4'h0, 4'h0, 3'd5}) begin
        $display("FAIL lat4_exec k=%0d: got %0h expected %0h", k,
                 {busy_c, ifc.rsp_valid, ifc.alu_a, ifc.alu_b, ifc.alu_sel}, {2'b10, 4'h0, 4'h0, 3'd5}); nerr++;
      end
      @(negedge clk);
    end
    #1; nvec++;
    if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_y, ifc.rsp_zero, ifc.rsp_carry} !== {2'b10, 8'h00, 2'b10}) begin
      $display("FAIL lat4_rsp: got %0h expected %0h",
               {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_y, ifc.rsp_zero, ifc.rsp_carry}, {2'b10, 8'h00, 2'b10}); nerr++;
    end
    @(negedge clk);
    #1; nvec++;
    if ({ops_c, ifc.alu_sel} !== {8'd1, 3'd5}) begin
      $display("FAIL lat4_done: got %0h expected %0h", {ops_c, ifc.alu_sel}, {8'd1, 3'd5}); nerr++;
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    ifc.req0_valid = 1; ifc.req0_a = 4'h7; ifc.req0_b = 4'h8; ifc.req0_sel = 3'd3;
    @(negedge clk);
    ifc.req0_valid = 0;
    #1; nvec++;
    if ({busy_c, ifc.alu_a} !== {1'b1, 4'h7}) begin
      $display("FAIL mid_exec: got %0h expected %0h", {busy_c, ifc.alu_a}, {1'b1, 4'h7}); nerr++;
    end
    @(negedge clk);
    rst_n = 0; #1; nvec++;
    if ({busy_c, ifc.rsp_valid, ifc.alu_a, ifc.alu_b, ifc.alu_sel, ops_c} !== 21'd0) begin
      $display("FAIL mid_reset: got %0h expected 0",
               {busy_c, ifc.rsp_valid, ifc.alu_a, ifc.alu_b, ifc.alu_sel, ops_c}); nerr++;
    end
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      #1; nvec++;
      if ({busy_c, ifc.rsp_valid} !== 2'b00) begin
        $display("FAIL mid_norsp k=%0d: got %b expected 00", k, {busy_c, ifc.rsp_valid}); nerr++;
      end
      @(negedge clk);
    end
    ifc.req0_valid = 1; ifc.req1_valid = 1;
    #1; nvec++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) begin
      $display("FAIL mid_tie: got %b expected 10", {ifc.req0_ready, ifc.req1_ready}); nerr++;
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_op();
    test_back_to_back();
    test_fixed_prio();
    test_backpressure();
    test_latency4();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
